// File: rtl/lookahead_ram_pkg.sv
// ----------------------------------------------------------------------------
// lookahead_ram_pkg
// Shared definitions for lookahead_multiport_ram and its read-port slices:
//   clog2()       - ceiling log2, used to size address buses
//   ram_state_e   - clear sequencer states
//   lane_merge()  - per-symbol merge of a write word over a memory word
// ----------------------------------------------------------------------------
package lookahead_ram_pkg;

    // Widest word lane_merge() handles; callers zero-extend into it.
    localparam int MAX_DW = 256;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Symbol i of the result comes from wr_word when byteenable[i] is set,
    // otherwise from mem_word. sym_w is the symbol width in bits.
    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0] mem_word,
        input logic [MAX_DW-1:0] wr_word,
        input logic [MAX_DW-1:0] byteenable,
        input int                sym_w
    );
        logic [MAX_DW-1:0] mask;
        logic [MAX_DW-1:0] be_sh;
        mask = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            be_sh   = byteenable >> (i / sym_w);
            mask[i] = be_sh[0];
        end
        return (wr_word & mask) | (mem_word & ~mask);
    endfunction

endpackage

// File: rtl/lookahead_ram_rd_port.sv
// ----------------------------------------------------------------------------
// lookahead_ram_rd_port
// One read port of lookahead_multiport_ram. Registers the write/read address
// compare and the write data/byte-enables, then merges them over the
// registered memory word so a read sees a write issued at the same edge.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   rd_addr_i      read address presented this cycle
//   rd_word_i      registered memory word (old data on collision)
//   wr_accept_i    a qualified write happens at this edge
//   wr_addr_i      write address
//   wr_data_i      write data
//   wr_be_i        write symbol enables
//   rd_data_o      read data, one cycle after rd_addr_i is sampled
// ----------------------------------------------------------------------------
module lookahead_ram_rd_port
    import lookahead_ram_pkg::*;
#(
    parameter  int AW           = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int SYMBOL_WIDTH = 8,
    localparam int NSYM         = DATA_WIDTH / SYMBOL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [AW-1:0]         rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rd_word_i,
    input  logic                  wr_accept_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [NSYM-1:0]       wr_be_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic                  hit_d, hit_q;
    logic                  zero_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [NSYM-1:0]       byp_be_q;
    logic [NSYM-1:0]       eff_be;
    logic [MAX_DW-1:0]     merged;
    logic                  unused_merged_hi;

    assign hit_d = wr_accept_i && (wr_addr_i == rd_addr_i);

    // zero_q forces a clean 0 output from reset until the first edge after
    // release, since the memory word register itself is not reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            hit_q  <= hit_d;
            zero_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        byp_data_q <= wr_data_i;
        byp_be_q   <= wr_be_i;
    end

    always_comb begin
        eff_be    = hit_q ? byp_be_q : '0;
        merged    = lane_merge(MAX_DW'(rd_word_i), MAX_DW'(byp_data_q),
                               MAX_DW'(eff_be), SYMBOL_WIDTH);
        rd_data_o = zero_q ? '0 : merged[DATA_WIDTH-1:0];
    end

    assign unused_merged_hi = ^merged[MAX_DW-1:DATA_WIDTH];

endmodule

// File: rtl/lookahead_multiport_ram.sv
// ----------------------------------------------------------------------------
// lookahead_multiport_ram
// One write port, NUM_RD registered read ports, per-symbol write enables and
// an optional zero-fill after reset. A read sampled at the same edge as a
// write to the same address returns the newly written symbols.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   wr_address       write word address (>= DEPTH is dropped)
//   wr_writedata     write data
//   wr_byteenable    per-symbol enable, bit i = symbol i
//   wr_write         write strobe
//   wr_waitrequest   1 while in reset or clearing; writes then ignored
//   rd_address       port k address at [k*AW +: AW]
//   rd_readdata      port k data at [k*DATA_WIDTH +: DATA_WIDTH]
// ----------------------------------------------------------------------------
module lookahead_multiport_ram
    import lookahead_ram_pkg::*;
#(
    parameter  int DEPTH          = 16,
    parameter  int DATA_WIDTH     = 32,
    parameter  int SYMBOL_WIDTH   = 8,
    parameter  int NUM_RD         = 2,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int AW             = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int NSYM           = DATA_WIDTH / SYMBOL_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [AW-1:0]                wr_address,
    input  logic [DATA_WIDTH-1:0]        wr_writedata,
    input  logic [NSYM-1:0]              wr_byteenable,
    input  logic                         wr_write,
    output logic                         wr_waitrequest,
    input  logic [NUM_RD*AW-1:0]         rd_address,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_readdata
);

    // One extra bit so DEPTH itself is representable for range compares.
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    ram_state_e            state_q;
    logic [AW-1:0]         clr_count_q;
    logic                  waitreq_q;

    logic                  clearing;
    logic                  wr_accept;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NSYM-1:0]       mem_be;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Clear sequencer: walks clr_count down from DEPTH-1 to 0, one word per
    // cycle, and opens the write port after the word-0 write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clr_count_q <= (CLEAR_ON_RESET != 0) ? LAST : '0;
            waitreq_q   <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if ((CLEAR_ON_RESET == 0) || (clr_count_q == '0)) begin
                        state_q   <= READY;
                        waitreq_q <= 1'b0;
                    end else begin
                        clr_count_q <= clr_count_q - 1'b1;
                    end
                end
                READY: begin
                    waitreq_q <= 1'b0;
                end
                default: begin
                    state_q   <= CLEAR;
                    waitreq_q <= 1'b1;
                end
            endcase
        end
    end

    assign wr_waitrequest = waitreq_q;

    // Clear writes and user writes never overlap: waitrequest is high for the
    // whole clear, so wr_accept is 0 whenever clearing is 1.
    always_comb begin
        clearing  = (state_q == CLEAR) && (CLEAR_ON_RESET != 0);
        wr_accept = wr_write && !waitreq_q && ({1'b0, wr_address} < DEPTH_X);
        mem_we    = clearing || wr_accept;
        mem_addr  = clearing ? clr_count_q : wr_address;
        mem_wdata = clearing ? '0 : wr_writedata;
        mem_be    = clearing ? '1 : wr_byteenable;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int s = 0; s < NSYM; s++) begin
                if (mem_be[s]) begin
                    mem_q[mem_addr][s*SYMBOL_WIDTH +: SYMBOL_WIDTH]
                        <= mem_wdata[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]         addr;
        logic                  in_range;
        logic [DATA_WIDTH-1:0] word_q;

        assign addr     = rd_address[k*AW +: AW];
        assign in_range = ({1'b0, addr} < DEPTH_X);

        // Plain registered read: returns pre-write contents on a collision;
        // the port slice overlays the same-edge write.
        always_ff @(posedge clk) begin
            word_q <= in_range ? mem_q[addr] : '0;
        end

        lookahead_ram_rd_port #(
            .AW           (AW),
            .DATA_WIDTH   (DATA_WIDTH),
            .SYMBOL_WIDTH (SYMBOL_WIDTH)
        ) u_port (
            .clk          (clk),
            .reset_n      (reset_n),
            .rd_addr_i    (addr),
            .rd_word_i    (word_q),
            .wr_accept_i  (wr_accept),
            .wr_addr_i    (wr_address),
            .wr_data_i    (wr_writedata),
            .wr_be_i      (wr_byteenable),
            .rd_data_o    (rd_readdata[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_lookahead_multiport_ram.sv
// ----------------------------------------------------------------------------
// tb_lookahead_multiport_ram
// Scoreboard bench. The driver computes expected read data from a plain
// array model of the memory and queues it tagged with the clock edge at
// which the DUT samples; a monitor on the falling edge pops and compares.
// DEPTH=20 (AW=5) so addresses 20..31 exist on the bus and exercise the
// out-of-range rules.
// ----------------------------------------------------------------------------
module tb_lookahead_multiport_ram;

    localparam int DEPTH = 20;
    localparam int DW    = 32;
    localparam int SW    = 8;
    localparam int NRD   = 3;
    localparam int AW    = 5;
    localparam int NSYM  = DW / SW;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [AW-1:0]       wr_address = '0;
    logic [DW-1:0]       wr_writedata = '0;
    logic [NSYM-1:0]     wr_byteenable = '0;
    logic                wr_write = 1'b0;
    logic                wr_waitrequest;
    logic [NRD*AW-1:0]   rd_address = '0;
    logic [NRD*DW-1:0]   rd_readdata;

    always #5 clk = ~clk;

    lookahead_multiport_ram #(
        .DEPTH          (DEPTH),
        .DATA_WIDTH     (DW),
        .SYMBOL_WIDTH   (SW),
        .NUM_RD         (NRD),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_address     (wr_address),
        .wr_writedata   (wr_writedata),
        .wr_byteenable  (wr_byteenable),
        .wr_write       (wr_write),
        .wr_waitrequest (wr_waitrequest),
        .rd_address     (rd_address),
        .rd_readdata    (rd_readdata)
    );

    typedef struct {
        int                       due;
        int                       tag;
        logic [NRD-1:0]           chk;
        logic [NRD-1:0][DW-1:0]   data;
        logic                     chk_wr;
        logic                     exp_wr;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        done = 1'b0;
    logic [DW-1:0] model [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation whose sampling edge has passed.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            for (int k = 0; k < NRD; k++) begin
                if (e.chk[k]) begin
                    checks++;
                    if (rd_readdata[k*DW +: DW] !== e.data[k]) begin
                        errors++;
                        $display("FAIL tag%0d port%0d readdata: got %h expected %h (t=%0t)",
                                 e.tag, k, rd_readdata[k*DW +: DW], e.data[k], $time);
                    end
                end
            end
            if (e.chk_wr) begin
                checks++;
                if (wr_waitrequest !== e.exp_wr) begin
                    errors++;
                    $display("FAIL tag%0d waitrequest: got %b expected %b (t=%0t)",
                             e.tag, wr_waitrequest, e.exp_wr, $time);
                end
            end
        end
        if (done) begin
            checks++;
            if (sbq.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] merge_m(input logic [DW-1:0] old_w,
                                              input logic [DW-1:0] new_w,
                                              input logic [NSYM-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < NSYM; b++)
            if (be[b]) r[b*SW +: SW] = new_w[b*SW +: SW];
        return r;
    endfunction

    task automatic idle();
        wr_write      = 1'b0;
        wr_address    = '0;
        wr_writedata  = '0;
        wr_byteenable = '0;
    endtask

    // Expect all-zero read data and waitrequest=1 right now (reset state).
    task automatic push_reset_state(input int tag);
        exp_t e;
        e.due    = cyc;
        e.tag    = tag;
        e.chk    = '1;
        e.data   = '0;
        e.chk_wr = 1'b1;
        e.exp_wr = 1'b1;
        sbq.push_back(e);
    endtask

    // Release reset (called just after a rising edge) and walk through the
    // clear: waitrequest stays high for DEPTH edges, then drops. Any write
    // pattern on the bus during this is expected to be discarded.
    task automatic release_and_clear();
        exp_t e;
        int   m;
        reset_n = 1'b1;
        m = cyc;
        for (int i = 0; i <= DEPTH; i++) begin
            e.due    = m + i;
            e.tag    = 2;
            e.chk    = '0;
            e.data   = '0;
            e.chk_wr = 1'b1;
            e.exp_wr = (i < DEPTH);
            sbq.push_back(e);
        end
        repeat (DEPTH) @(posedge clk);
        #1;
        idle();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // One READY-state cycle: drive, queue expectations, advance an edge.
    // use_c replaces the model result with a fixed expected constant.
    task automatic cycle(input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [NSYM-1:0] be,
                         input logic [NRD-1:0][AW-1:0] ra, input int tag,
                         input logic use_c, input logic [DW-1:0] cval);
        exp_t e;
        logic acc;
        wr_write      = we;
        wr_address    = wa;
        wr_writedata  = wd;
        wr_byteenable = be;
        rd_address    = ra;
        acc = we && (int'(wa) < DEPTH);
        e.due    = cyc + 1;
        e.tag    = tag;
        e.chk    = '1;
        e.chk_wr = 1'b1;
        e.exp_wr = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            if (int'(ra[k]) >= DEPTH) e.data[k] = '0;
            else begin
                e.data[k] = model[ra[k]];
                if (acc && wa == ra[k]) e.data[k] = merge_m(model[ra[k]], wd, be);
            end
            if (use_c) e.data[k] = cval;
        end
        if (acc) model[wa] = merge_m(model[wa], wd, be);
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rd_all(input logic [AW-1:0] a, input int tag,
                          input logic use_c, input logic [DW-1:0] cval);
        logic [NRD-1:0][AW-1:0] ra;
        for (int k = 0; k < NRD; k++) ra[k] = a;
        cycle(1'b0, '0, '0, '0, ra, tag, use_c, cval);
    endtask

    task automatic random_run(input int n, input int tag);
        logic [NRD-1:0][AW-1:0] ra;
        logic [AW-1:0] wa;
        for (int i = 0; i < n; i++) begin
            wa = AW'($urandom_range(0, 23));
            for (int k = 0; k < NRD; k++)
                ra[k] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 23));
            cycle(1'($urandom_range(0, 1)), wa, $urandom(),
                  NSYM'($urandom_range(0, 15)), ra, tag, 1'b0, '0);
        end
    endtask

    initial begin
        logic [NRD-1:0][AW-1:0] ra;
        idle();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_reset_state(1);
        @(posedge clk);
        #1;

        // Writes attempted throughout the clear must not land.
        wr_write      = 1'b1;
        wr_address    = AW'(19);
        wr_writedata  = '1;
        wr_byteenable = '1;
        release_and_clear();

        for (int a = 0; a < DEPTH; a++) rd_all(AW'(a), 3, 1'b1, 32'h0);

        rd_all(AW'(5), 4, 1'b0, '0);
        cycle(1'b1, AW'(5), 32'hDEADBEEF, 4'b1111, {AW'(5), AW'(5), AW'(5)}, 4, 1'b0, '0);
        cycle(1'b1, AW'(5), 32'h00000011, 4'b0001, {AW'(5), AW'(5), AW'(5)}, 5, 1'b1, 32'hDEADBE11);
        rd_all(AW'(5), 6, 1'b1, 32'hDEADBE11);

        cycle(1'b1, AW'(3), 32'h11223344, 4'b1111, {AW'(2), AW'(1), AW'(0)}, 7, 1'b0, '0);
        cycle(1'b1, AW'(3), 32'hCAFEF00D, 4'b0110, {AW'(3), AW'(3), AW'(3)}, 8, 1'b1, 32'h11FEF044);
        rd_all(AW'(3), 9, 1'b1, 32'h11FEF044);

        // Out-of-range write with same-edge reads of 20, its 4-bit alias 4, and 31.
        cycle(1'b1, AW'(20), 32'hAAAAAAAA, 4'b1111, {AW'(31), AW'(4), AW'(20)}, 10, 1'b1, 32'h0);
        for (int a = 0; a < DEPTH; a++) rd_all(AW'(a), 11, 1'b0, '0);

        random_run(200, 12);

        cycle(1'b1, AW'(0), 32'h12345678, 4'b1111, {AW'(0), AW'(0), AW'(0)}, 13, 1'b1, 32'h12345678);
        idle();
        // Reset lands between edges; outputs must drop before the next edge.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        push_reset_state(20);
        repeat (2) @(posedge clk);
        #1;
        release_and_clear();

        for (int k = 0; k < NRD; k++) ra[k] = AW'(k);
        cycle(1'b0, '0, '0, '0, ra, 21, 1'b1, 32'h0);
        random_run(1000, 14);

        idle();
        repeat (3) @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
